// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with per-16-bit-lane writes,
// synchronous clear-all and a pending-write scoreboard that stalls the
// decoder on RAW (operand owed a writeback) and WAW (destination owed one).
// Optional macro WRITE_BYPASS_EN: same-cycle write data is forwarded to the
// read ports (merged with the old contents in unwritten lanes), and a
// forwarded operand no longer stalls on its pending bit.
module reg_file_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned LANES    = DATA_W / 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   read_addr1,
  input  logic [ADDR_W-1:0]   read_addr2,
  input  logic                read_en1,
  input  logic                read_en2,
  output logic [DATA_W-1:0]   value1,
  output logic [DATA_W-1:0]   value2,
  input  logic [ADDR_W-1:0]   write_addr,
  input  logic [DATA_W-1:0]   write_value_alu,
  input  logic [DATA_W-1:0]   write_value_id,
  input  logic                write_data_sel,
  input  logic                write_enable,
  input  logic [LANES-1:0]    write_lane,
  input  logic                clear_all,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_addr,
  output logic [NUM_REGS-1:0] pending,
  output logic                stall
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   wr_src;
  logic [DATA_W-1:0]   wr_merged;
  logic [NUM_REGS-1:0] pending_nxt;
  logic                byp1;
  logic                byp2;

  // Source select and lane merge of the write data over the destination's old contents
  always_comb begin
    wr_src    = write_data_sel ? write_value_id : write_value_alu;
    wr_merged = regs[write_addr];
    for (int unsigned l = 0; l < LANES; l++) begin
      if (write_lane[l]) begin
        wr_merged[16*l +: 16] = wr_src[16*l +: 16];
      end
    end
  end

`ifdef WRITE_BYPASS_EN
  assign byp1 = write_enable && (read_addr1 == write_addr);
  assign byp2 = write_enable && (read_addr2 == write_addr);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // Combinational read ports; a forwarded port returns the merged write result
  always_comb begin
    value1 = byp1 ? wr_merged : regs[read_addr1];
    value2 = byp2 ? wr_merged : regs[read_addr2];
  end

  // Hazard detection: RAW on either consumed operand, WAW on the issue destination
  always_comb begin
    stall = (read_en1 && !byp1 && pending[read_addr1]) ||
            (read_en2 && !byp2 && pending[read_addr2]) ||
            (issue_valid && pending[issue_addr]);
  end

  // Scoreboard next state; the issue term is applied last so a same-register set beats a clear
  always_comb begin
    pending_nxt = pending;
    if (write_enable && (write_lane != '0)) begin
      pending_nxt[write_addr] = 1'b0;
    end
    if (issue_valid && !stall) begin
      pending_nxt[issue_addr] = 1'b1;
    end
  end

  // Register array storage with clear-all priority over the write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (clear_all) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_enable) begin
      regs[write_addr] <= wr_merged;
    end
  end

  // Scoreboard storage with clear-all priority over issue and writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (clear_all) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed and randomized checks of reg_file_sb against an
// array/mask-based model of the register file and scoreboard.
module tb_reg_file_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned LN = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] read_addr1, read_addr2, write_addr, issue_addr;
  logic          read_en1, read_en2;
  logic [DW-1:0] value1, value2;
  logic [DW-1:0] write_value_alu, write_value_id;
  logic          write_data_sel, write_enable, clear_all, issue_valid;
  logic [LN-1:0] write_lane;
  logic [NR-1:0] pending;
  logic          stall;

  reg_file_sb #(.DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_en1(read_en1), .read_en2(read_en2),
    .value1(value1), .value2(value2),
    .write_addr(write_addr), .write_value_alu(write_value_alu),
    .write_value_id(write_value_id), .write_data_sel(write_data_sel),
    .write_enable(write_enable), .write_lane(write_lane),
    .clear_all(clear_all), .issue_valid(issue_valid), .issue_addr(issue_addr),
    .pending(pending), .stall(stall)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  bit          chk_en = 1'b0;

  logic [DW-1:0] mdl [NR];
  logic [NR-1:0] mdl_pend;

`ifdef WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] lane_mask(input logic [LN-1:0] ln);
    logic [DW-1:0] m = '0;
    for (int k = 0; k < int'(LN); k++)
      if (ln[k]) m = m | (DW'(32'hFFFF) << (16 * k));
    return m;
  endfunction

  function automatic logic [DW-1:0] merged(input logic [DW-1:0] old_v);
    logic [DW-1:0] m   = lane_mask(write_lane);
    logic [DW-1:0] src = write_data_sel ? write_value_id : write_value_alu;
    return (old_v & ~m) | (src & m);
  endfunction

  function automatic logic [DW-1:0] exp_value(input logic [AW-1:0] a);
    if (BYP && write_enable && a == write_addr) return merged(mdl[a]);
    return mdl[a];
  endfunction

  function automatic logic exp_stall();
    logic p1 = read_en1 && mdl_pend[read_addr1];
    logic p2 = read_en2 && mdl_pend[read_addr2];
    if (BYP && write_enable && read_addr1 == write_addr) p1 = 1'b0;
    if (BYP && write_enable && read_addr2 == write_addr) p2 = 1'b0;
    return p1 || p2 || (issue_valid && mdl_pend[issue_addr]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NR); i++) mdl[i] = '0;
    mdl_pend = '0;
  endtask

  // Model edge update, evaluated from the inputs that were present before the edge
  task automatic model_edge();
    logic s = exp_stall();
    if (clear_all) begin
      model_reset();
    end else begin
      if (write_enable) mdl[write_addr] = merged(mdl[write_addr]);
      if (write_enable && write_lane != '0) mdl_pend[write_addr] = 1'b0;
      if (issue_valid && !s) mdl_pend[issue_addr] = 1'b1;
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("value1", value1, exp_value(read_addr1));
      chk("value2", value2, exp_value(read_addr2));
      chk("stall", 32'(stall), 32'(exp_stall()));
      chk("pending", 32'(pending), 32'(mdl_pend));
    end
  end

  task automatic idle();
    read_addr1 = '0; read_addr2 = '0; read_en1 = 0; read_en2 = 0;
    write_addr = '0; write_value_alu = '0; write_value_id = '0;
    write_data_sel = 0; write_enable = 0; write_lane = '0;
    clear_all = 0; issue_valid = 0; issue_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [LN-1:0] ln);
    idle();
    write_enable = 1; write_addr = a; write_data_sel = 1; write_value_id = d; write_lane = ln;
    step();
  endtask

  initial begin
    idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk_en = 1;
    #1;
    // reset state
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_r0", value1, 32'h0);

    // 1: MOV then MOVT into R0
    wr(3'd0, 32'h0000FFFF, 2'b11);
    wr(3'd0, 32'hEEEE0000, 2'b10);
    idle(); #1;
    chk("movt_r0", value1, 32'hEEEEFFFF);

    // 2: low-lane ALU write, then empty lane mask
    wr(3'd3, 32'hAAAA1234, 2'b11);
    idle(); write_enable = 1; write_addr = 3; write_value_alu = 32'h5; write_lane = 2'b01;
    step();
    idle(); read_addr1 = 3; #1;
    chk("lane01_r3", value1, 32'hAAAA0005);
    idle(); write_enable = 1; write_addr = 3; write_value_alu = 32'hFFFFFFFF; write_lane = 2'b00;
    step();
    idle(); read_addr1 = 3; #1;
    chk("lane00_r3", value1, 32'hAAAA0005);

    // 3: RAW stall until writeback
    idle(); issue_valid = 1; issue_addr = 2;
    step();
    idle(); read_en1 = 1; read_addr1 = 2; #1;
    chk("raw_stall", 32'(stall), 32'h1);
    chk("raw_pending", 32'(pending), 32'h04);
    write_enable = 1; write_addr = 2; write_data_sel = 1; write_value_id = 32'h12345678; write_lane = 2'b11;
    step();
    idle(); read_en1 = 1; read_addr1 = 2; #1;
    chk("wb_pending", 32'(pending), 32'h00);
    chk("wb_stall", 32'(stall), 32'h0);

    // 4: WAW stall, then set-wins on a same-edge write and issue
    idle(); issue_valid = 1; issue_addr = 5;
    step();
    #1 chk("waw_stall", 32'(stall), 32'h1);
    step();
    chk("waw_pending", 32'(pending), 32'h20);
    wr(3'd5, 32'h1, 2'b11);
    chk("waw_clear", 32'(pending), 32'h00);
    idle(); issue_valid = 1; issue_addr = 5;
    write_enable = 1; write_addr = 5; write_value_alu = 32'h2; write_lane = 2'b11;
    step();
    chk("set_wins", 32'(pending), 32'h20);
    wr(3'd5, 32'h3, 2'b01);

    // 5: clear_all overrides a same-cycle write and issue
    for (int i = 0; i < 8; i++) wr(3'(i), 32'(i + 1), 2'b11);
    idle(); issue_valid = 1; issue_addr = 4;
    step();
    chk("pend4", 32'(pending), 32'h10);
    idle(); clear_all = 1; write_enable = 1; write_addr = 1; write_data_sel = 1;
    write_value_id = 32'hFFFFFFFF; write_lane = 2'b11; issue_valid = 1; issue_addr = 2;
    step();
    idle(); #1;
    chk("clr_pending", 32'(pending), 32'h0);
    for (int i = 0; i < 8; i++) begin
      read_addr1 = 3'(i); #1;
      chk("clr_reg", value1, 32'h0);
    end
    // mid-cycle asynchronous reset
    wr(3'd7, 32'h8, 2'b11);
    idle(); issue_valid = 1; issue_addr = 3;
    step();
    idle(); read_addr1 = 7; #1;
    chk("pre_rst_r7", value1, 32'h8);
    rst_n = 0; model_reset(); #1;
    chk("async_r7", value1, 32'h0);
    chk("async_pend", 32'(pending), 32'h0);
    #1 rst_n = 1;

    // 6: same-cycle partial write to R6 observed on port 2
    wr(3'd6, 32'h11112222, 2'b11);
    idle(); write_enable = 1; write_addr = 6; write_value_alu = 32'h3333; write_lane = 2'b01;
    read_addr2 = 6; #1;
    chk("bypass_r6", value2, BYP ? 32'h11113333 : 32'h11112222);
    step();
    idle(); read_addr2 = 6; #1;
    chk("after_r6", value2, 32'h11113333);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      read_addr1      = 3'($urandom_range(0, 7));
      read_addr2      = 3'($urandom_range(0, 7));
      read_en1        = ($urandom_range(0, 1) == 1);
      read_en2        = ($urandom_range(0, 1) == 1);
      write_addr      = 3'($urandom_range(0, 7));
      write_value_alu = $urandom;
      write_value_id  = $urandom;
      write_data_sel  = ($urandom_range(0, 1) == 1);
      write_enable    = ($urandom_range(0, 2) != 0);
      write_lane      = 2'($urandom_range(0, 3));
      clear_all       = ($urandom_range(0, 59) == 0);
      issue_valid     = ($urandom_range(0, 2) == 0);
      issue_addr      = 3'($urandom_range(0, 7));
      step();
    end

    idle();
    @(negedge clk);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the 8x32 register file that sits between the instruction decoder and the EXE stage.
- Adds generic width and depth, per-halfword write lanes (for MOV/MOVT partial writes), an explicit clear-all, and a pending-write scoreboard.
- The scoreboard produces a stall to the decoder when an operand or destination is still owed a writeback from a multi-cycle operation.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 16.
- NUM_REGS, 8, number of registers; must be a power of two, at least 2.
- ADDR_W, $clog2(NUM_REGS), register address width (derived; not overridden).
- LANES, DATA_W/16, number of 16-bit write lanes (derived).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- read_addr1  in  ADDR_W  read port 1 address.
- read_addr2  in  ADDR_W  read port 2 address.
- read_en1  in  1  port 1 operand is consumed this cycle (hazard check only).
- read_en2  in  1  port 2 operand is consumed this cycle (hazard check only).
- value1  out  DATA_W  combinational read data, port 1.
- value2  out  DATA_W  combinational read data, port 2.
- write_addr  in  ADDR_W  write destination.
- write_value_alu  in  DATA_W  write data from EXE.
- write_value_id  in  DATA_W  write data from decoder (immediates).
- write_data_sel  in  1  0 selects alu, 1 selects id.
- write_enable  in  1  write strobe.
- write_lane  in  LANES  per-16-bit-lane write mask; bit i covers bits [16i+15:16i].
- clear_all  in  1  synchronous clear of every register and the scoreboard.
- issue_valid  in  1  a multi-cycle op targeting issue_addr is issued this cycle.
- issue_addr  in  ADDR_W  destination of the issued op.
- pending  out  NUM_REGS  scoreboard; bit r set means register r is owed a write.
- stall  out  1  combinational hazard indication to the decoder.

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0, pending 0. stall therefore resolves to 0.
- Register 0 is an ordinary writable register, not hardwired.
- Write: on a rising edge with write_enable=1, each lane i with write_lane[i]=1 takes the selected source's lane i. Unselected lanes hold their value.
  - MOV uses write_lane=all ones, with the zero-extended immediate.
  - MOVT uses only the upper lane.
- write_enable=1 with write_lane=0 is a no-op. It does not clear pending.
- Read: value1/value2 = register contents, combinational. Both ports may address the same register.
- Scoreboard, each edge, for register r:
  - Set if issue_valid and issue_addr==r and stall==0.
  - Clear if write_enable, write_addr==r and write_lane!=0.
  - Simultaneous set and clear on the same r: set wins; the new issue owns the register.
- stall = (read_en1 & pending[read_addr1]) | (read_en2 & pending[read_addr2]) | (issue_valid & pending[issue_addr]).
  - The last term blocks WAW.
  - While stall=1, issue_valid does not set pending.
  - Writes still occur during stall; stall never blocks the writeback port.
- clear_all (synchronous): all registers and pending go to 0 on the edge.
  - Overrides a same-cycle write and a same-cycle issue.
- Reset asserted mid-operation: immediate clear of all state. Outputs are valid the same delta; no partial writes survive.
- Latency:
  - A write is visible on value1/value2 the cycle after the edge.
  - A pending clear de-asserts stall in the cycle after the write edge.

Optional Feature:
- WRITE_BYPASS_EN
- Defined: if write_enable=1 and read_addrN==write_addr, valueN returns the merged result: new data in written lanes, old data elsewhere. In that case stall ignores pending for that port, since a same-cycle writeback satisfies the operand.
- Undefined: reads return pre-edge contents and stall follows the base equation.
- No other behaviour differs.

Test Plan:
1. Reset, then write_enable, write_lane=11, sel=id, write_value_id=0x0000FFFF to R0. Next, write_lane=10 with id=0xEEEE0000 -> value1 (addr 0) = 0xEEEEFFFF.
2. Write 0x5 via alu to R3 with write_lane=01, prior contents 0xAAAA1234 -> R3=0xAAAA0005. Repeat with write_lane=00 -> R3 unchanged.
3. issue_valid, issue_addr=2. Next cycle read_en1 with read_addr1=2 -> stall=1, pending=0x04. Write R2 with lanes 11 -> pending=0x00, stall=0 the following cycle.
4. With pending[5]=1: issue_valid to 5 -> stall=1 and pending unchanged. Same edge as a write to 5, with issue to 5 while not stalled -> pending[5] stays 1.
5. Load R0..R7 with 0x1..0x8, set pending[4]. Pulse clear_all with a concurrent write of 0xFFFFFFFF to R1 -> every register 0, pending 0. Repeat with rst_n pulsed low mid-cycle -> immediate zero.
6. With WRITE_BYPASS_EN: R6=0x11112222 and a same-cycle write of lane 01 value 0x3333 to R6 -> value2 (addr 6) = 0x11113333 in that cycle. Without the macro -> 0x11112222 in that cycle.
